inst_fetcher: RTL

- Instruction-fetch stage that feeds the memory controller's instruction port and the downstream instruction queue.
- Holds the PC and a direct-mapped instruction cache.
- Hits return in 1 cycle. Misses issue a held 32-bit fetch request to the memory controller and fill the cache on done.
- Accepts redirects (jump/flush) from the commit/branch logic at any time.

---
 rtl/inst_fetcher_pkg.sv | 23 ++
 rtl/inst_fetcher_if.sv | 27 ++
 rtl/inst_fetcher_icache_array.sv | 46 ++++
 rtl/inst_fetcher.sv | 132 +++++++++++++
 4 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared widths, state encoding and cache geometry defaults for the instruction fetcher.
// JAL_PREDICT_EN (optional macro) enables static JAL target prediction in inst_fetcher.
package inst_fetcher_pkg;

    localparam int AddrBus          = 32;
    localparam int InstBus          = 32;
    localparam int ICACHE_LINES_DEF = 64;
    localparam int INDEX_W_DEF      = 6;

    localparam logic [6:0] JAL_OPCODE = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MISS       = 2'd1,
        MISS_FLUSH = 2'd2
    } fetch_state_t;

    // Sign-extended J-type immediate {imm[20|10:1|11|19:12], 0}.
    function automatic logic [AddrBus-1:0] jal_offset(input logic [InstBus-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetcher-facing bundle: memory controller request/response, redirect input and IQ delivery.
// The fetcher itself uses the master modport; the surrounding system uses slave.
interface inst_fetcher_if;
    import inst_fetcher_pkg::*;

    logic               mc_en;
    logic [AddrBus-1:0] mc_addr;
    logic               mc_done;
    logic [InstBus-1:0] mc_inst;
    logic               jump_en;
    logic [AddrBus-1:0] jump_pc;
    logic               iq_full;
    logic               iq_en;
    logic [InstBus-1:0] iq_inst;
    logic [AddrBus-1:0] iq_pc;

    modport master (
        output mc_en, mc_addr, iq_en, iq_inst, iq_pc,
        input  mc_done, mc_inst, jump_en, jump_pc, iq_full
    );

    modport slave (
        input  mc_en, mc_addr, iq_en, iq_inst, iq_pc,
        output mc_done, mc_inst, jump_en, jump_pc, iq_full
    );

endinterface

// File: rtl/inst_fetcher_icache_array.sv
// Direct-mapped instruction cache storage: one instruction per line, combinational read,
// synchronous write, valid bits cleared asynchronously on rst.
module icache_array
    import inst_fetcher_pkg::*;
#(
    parameter int LINES   = ICACHE_LINES_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = AddrBus - INDEX_W - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [InstBus-1:0] rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [InstBus-1:0] wr_data
);

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [InstBus-1:0] data [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: PC, direct-mapped icache lookup, miss handling toward the memory
// controller and single-instruction delivery to the IQ. Optional macro: JAL_PREDICT_EN.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int               ICACHE_LINES = ICACHE_LINES_DEF,
    parameter int               INDEX_W      = INDEX_W_DEF,
    parameter logic [AddrBus-1:0] RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    inst_fetcher_if.master bus
);

    localparam int TAG_W = AddrBus - INDEX_W - 2;

    fetch_state_t       state, state_nx;
    logic [AddrBus-1:0] pc, pc_nx;
    logic               mc_en, mc_en_nx;
    logic [AddrBus-1:0] mc_addr, mc_addr_nx;
    logic               iq_en, iq_en_nx;
    logic [InstBus-1:0] iq_inst, iq_inst_nx;
    logic [AddrBus-1:0] iq_pc, iq_pc_nx;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [InstBus-1:0] rd_data;
    logic               hit;
    logic               fill;
    logic [AddrBus-1:0] seq_pc;

    icache_array #(
        .LINES   (ICACHE_LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc[INDEX_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill),
        .wr_idx   (mc_addr[INDEX_W+1:2]),
        .wr_tag   (mc_addr[AddrBus-1:INDEX_W+2]),
        .wr_data  (bus.mc_inst)
    );

    assign hit = rd_valid && (rd_tag == pc[AddrBus-1:INDEX_W+2]);

    // A redirect during the miss only moves pc; the outstanding line is still filled.
    assign fill = rdy && (state != IDLE) && bus.mc_done;

`ifdef JAL_PREDICT_EN
    assign seq_pc = (rd_data[6:0] == JAL_OPCODE) ? pc + jal_offset(rd_data) : pc + 32'd4;
`else
    assign seq_pc = pc + 32'd4;
`endif

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        mc_en_nx   = mc_en;
        mc_addr_nx = mc_addr;
        iq_en_nx   = iq_en;
        iq_inst_nx = iq_inst;
        iq_pc_nx   = iq_pc;
        case (state)
            IDLE: begin
                iq_en_nx = 1'b0;
                if (bus.jump_en) begin
                    pc_nx = bus.jump_pc;
                end else if (hit) begin
                    if (!bus.iq_full) begin
                        iq_en_nx   = 1'b1;
                        iq_inst_nx = rd_data;
                        iq_pc_nx   = pc;
                        pc_nx      = seq_pc;
                    end
                end else begin
                    mc_en_nx   = 1'b1;
                    mc_addr_nx = pc;
                    state_nx   = MISS;
                end
            end
            MISS, MISS_FLUSH: begin
                iq_en_nx = 1'b0;
                if (bus.jump_en) begin
                    pc_nx = bus.jump_pc;
                end
                if (bus.mc_done) begin
                    mc_en_nx = 1'b0;
                    state_nx = IDLE;
                end else if (bus.jump_en) begin
                    state_nx = MISS_FLUSH;
                end
            end
            default: begin
                state_nx = IDLE;
                iq_en_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            mc_en   <= 1'b0;
            mc_addr <= '0;
            iq_en   <= 1'b0;
            iq_inst <= '0;
            iq_pc   <= '0;
        end else if (rdy) begin
            state   <= state_nx;
            pc      <= pc_nx;
            mc_en   <= mc_en_nx;
            mc_addr <= mc_addr_nx;
            iq_en   <= iq_en_nx;
            iq_inst <= iq_inst_nx;
            iq_pc   <= iq_pc_nx;
        end
    end

    assign bus.mc_en   = mc_en;
    assign bus.mc_addr = mc_addr;
    assign bus.iq_en   = iq_en;
    assign bus.iq_inst = iq_inst;
    assign bus.iq_pc   = iq_pc;

endmodule
